// File: rtl/param_matched_filter_if.sv
// Sample-word stream bus for param_matched_filter: input word plus filtered word and status.
interface param_matched_filter_if #(
    parameter int NSAMP   = 2,
    parameter int INBITS  = 12,
    parameter int OUTBITS = 16
);
    logic [NSAMP*INBITS-1:0]  dat_i;
    logic                     valid_i;
    logic [NSAMP*OUTBITS-1:0] dat_o;
    logic                     valid_o;
    logic                     primed_o;
    logic                     ovf_o;

    modport master (
        output dat_i, valid_i,
        input  dat_o, valid_o, primed_o, ovf_o
    );

    modport slave (
        input  dat_i, valid_i,
        output dat_o, valid_o, primed_o, ovf_o
    );
endinterface

// File: rtl/param_matched_filter.sv
// Sample-parallel FIR matched filter with constant shift-add taps and a registered adder tree.
// Define PARAM_MATCHED_FILTER_SAT_EN to clamp out-of-range lanes instead of wrapping them.
module param_matched_filter #(
    parameter int                 INBITS  = 12,
    parameter int                 NSAMP   = 2,
    parameter int                 NTAPS   = 12,
    parameter logic [4*NTAPS-1:0] COEFFS  = 48'h110CF0100FFF,
    parameter int                 OUTBITS = 16
) (
    input logic                   clk_i,
    input logic                   rst_i,
    param_matched_filter_if.slave bus
);
    localparam int LV = $clog2(NTAPS);
    localparam int IW = INBITS + 4 + LV;
    localparam int H  = (NTAPS + NSAMP - 2) / NSAMP;
    localparam int WN = (H + 1) * NSAMP;
    localparam int TP = 1 << LV;
    localparam int CW = $clog2(H + 1);
    localparam logic signed [IW-1:0] MAXV = IW'((64'sd1 <<< (OUTBITS - 1)) - 64'sd1);
    localparam logic signed [IW-1:0] MINV = ~MAXV;

    if (OUTBITS > IW) begin : g_err_outbits
        $error("param_matched_filter: OUTBITS exceeds internal width");
    end
    if (NSAMP < 1) begin : g_err_nsamp
        $error("param_matched_filter: NSAMP must be at least 1");
    end
    if (NTAPS < 2) begin : g_err_ntaps
        $error("param_matched_filter: NTAPS must be at least 2");
    end

    logic signed [INBITS-1:0] win [WN];
    logic [CW-1:0]            cnt;
    logic                     primed;
    logic [LV+1:0]            vpipe;
    (* use_dsp = "no" *) logic signed [IW-1:0] tree [LV+1][NSAMP][TP];
    logic [NSAMP-1:0]         ovf_lane;
    logic [OUTBITS-1:0]       res [NSAMP];

    // Constant coefficient as two's-complement bit weights, so each tap folds to shift-adds.
    function automatic logic signed [IW-1:0] cmul(input logic signed [INBITS-1:0] x,
                                                  input logic [3:0] c);
        logic signed [IW-1:0] xe;
        xe   = {{(IW - INBITS){x[INBITS-1]}}, x};
        cmul = '0;
        if (c[0]) cmul = cmul + xe;
        if (c[1]) cmul = cmul + (xe <<< 1);
        if (c[2]) cmul = cmul + (xe <<< 2);
        if (c[3]) cmul = cmul - (xe <<< 3);
    endfunction

    assign primed       = (cnt == CW'(H));
    assign bus.primed_o = primed;

    // Window of the last H accepted words plus the newest one; index 0 is the oldest sample.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < WN; i++) win[i] <= '0;
            cnt   <= '0;
            vpipe <= '0;
        end else begin
            if (bus.valid_i) begin
                for (int i = 0; i < WN - NSAMP; i++) win[i] <= win[i + NSAMP];
                for (int j = 0; j < NSAMP; j++) win[WN - NSAMP + j] <= bus.dat_i[j*INBITS +: INBITS];
                if (!primed) cnt <= cnt + CW'(1);
            end
            vpipe <= {vpipe[LV:0], bus.valid_i & primed};
        end
    end

    // Tap products, then one registered pairwise-add level per tree stage; spare slots stay zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int l = 0; l <= LV; l++)
                for (int j = 0; j < NSAMP; j++)
                    for (int i = 0; i < TP; i++) tree[l][j][i] <= '0;
        end else begin
            for (int j = 0; j < NSAMP; j++) begin
                for (int i = 0; i < NTAPS; i++)
                    tree[0][j][i] <= cmul(win[H*NSAMP + j - i], COEFFS[4*i +: 4]);
                for (int i = NTAPS; i < TP; i++) tree[0][j][i] <= '0;
            end
            for (int l = 1; l <= LV; l++)
                for (int j = 0; j < NSAMP; j++) begin
                    for (int i = 0; i < (TP >> l); i++)
                        tree[l][j][i] <= tree[l-1][j][2*i] + tree[l-1][j][2*i+1];
                    for (int i = (TP >> l); i < TP; i++) tree[l][j][i] <= '0;
                end
        end
    end

    always_comb begin
        for (int j = 0; j < NSAMP; j++) begin
            ovf_lane[j] = (tree[LV][j][0] > MAXV) || (tree[LV][j][0] < MINV);
            res[j]      = tree[LV][j][0][OUTBITS-1:0];
`ifdef PARAM_MATCHED_FILTER_SAT_EN
            if (tree[LV][j][0] > MAXV) res[j] = MAXV[OUTBITS-1:0];
            else if (tree[LV][j][0] < MINV) res[j] = MINV[OUTBITS-1:0];
`endif
        end
    end

    // Output register: dat_o only updates on valid results, ovf_o is sticky until reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus.dat_o   <= '0;
            bus.valid_o <= 1'b0;
            bus.ovf_o   <= 1'b0;
        end else begin
            bus.valid_o <= vpipe[LV+1];
            if (vpipe[LV+1]) begin
                for (int j = 0; j < NSAMP; j++) bus.dat_o[j*OUTBITS +: OUTBITS] <= res[j];
                if (|ovf_lane) bus.ovf_o <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_param_matched_filter.sv
// Directed bench for param_matched_filter: warm-up, impulse, gaps, DC, overflow and mid-stream reset.
module tb_param_matched_filter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

`ifdef PARAM_MATCHED_FILTER_SAT_EN
    localparam int OVF_EXP = 2047;
`else
    localparam int OVF_EXP = -2048;
`endif

    localparam logic [23:0] IMPULSE = 24'h000064;
    localparam logic [23:0] DC_WORD = {12'd2047, 12'd2047};

    int exp_l0 [8] = '{-100, -100, 0, 0, -400, 100, 0, 0};
    int exp_l1 [8] = '{-100, 0, 100, -100, 0, 100, 0, 0};

    param_matched_filter_if #(.NSAMP(2), .INBITS(12), .OUTBITS(16)) bus_a ();
    param_matched_filter_if #(.NSAMP(2), .INBITS(12), .OUTBITS(12)) bus_b ();

    param_matched_filter dut_a (.clk_i(clk), .rst_i(rst), .bus(bus_a));
    param_matched_filter #(.OUTBITS(12)) dut_b (.clk_i(clk), .rst_i(rst), .bus(bus_b));

    always #5 clk = ~clk;

    task automatic step(input logic v, input logic [23:0] d);
        bus_a.valid_i = v;
        bus_a.dat_i   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus_a.valid_i = 1'b0;
        bus_a.dat_i   = '0;
        bus_b.valid_i = 1'b0;
        bus_b.dat_i   = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus_a.valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset valid_o: got %b want 0", bus_a.valid_o); end
        checks++; if (bus_a.primed_o !== 1'b0) begin errors++; $display("[TB] FAIL reset primed_o: got %b want 0", bus_a.primed_o); end
        checks++; if (bus_a.ovf_o !== 1'b0) begin errors++; $display("[TB] FAIL reset ovf_o: got %b want 0", bus_a.ovf_o); end
        checks++; if (bus_a.dat_o !== 32'h0) begin errors++; $display("[TB] FAIL reset dat_o: got %h want 0", bus_a.dat_o); end
        rst = 1'b0;
    endtask

    task automatic warmup_run(input string tag);
        for (int s = 1; s <= 14; s++) begin
            step(1'b1, '0);
            checks++;
            if (bus_a.primed_o !== (s >= 6)) begin
                errors++; $display("[TB] FAIL %s primed_o step %0d: got %b want %b", tag, s, bus_a.primed_o, (s >= 6));
            end
            checks++;
            if (bus_a.valid_o !== (s >= 13)) begin
                errors++; $display("[TB] FAIL %s valid_o step %0d: got %b want %b", tag, s, bus_a.valid_o, (s >= 13));
            end
            if (s == 13) begin
                checks++; if (bus_a.dat_o !== 32'h0) begin errors++; $display("[TB] FAIL %s dat_o: got %h want 0", tag, bus_a.dat_o); end
                checks++; if (bus_a.ovf_o !== 1'b0) begin errors++; $display("[TB] FAIL %s ovf_o: got %b want 0", tag, bus_a.ovf_o); end
            end
        end
    endtask

    task automatic test_warmup();
        warmup_run("warmup");
    endtask

    task automatic test_impulse();
        logic signed [15:0] g0, g1;
        for (int i = 0; i < 14; i++) begin
            step(1'b1, (i == 0) ? IMPULSE : 24'h0);
            if (i >= 6) begin
                g0 = bus_a.dat_o[15:0];
                g1 = bus_a.dat_o[31:16];
                checks++; if (bus_a.valid_o !== 1'b1) begin errors++; $display("[TB] FAIL impulse valid_o %0d: got %b want 1", i - 6, bus_a.valid_o); end
                checks++; if (g0 !== 16'(exp_l0[i-6])) begin errors++; $display("[TB] FAIL impulse lane0 %0d: got %0d want %0d", i - 6, g0, exp_l0[i-6]); end
                checks++; if (g1 !== 16'(exp_l1[i-6])) begin errors++; $display("[TB] FAIL impulse lane1 %0d: got %0d want %0d", i - 6, g1, exp_l1[i-6]); end
            end
        end
    endtask

    task automatic test_gapped();
        logic signed [15:0] g0, g1, w0, w1;
        logic v, vexp;
        int k;
        k  = 0;
        w0 = '0;
        w1 = '0;
        for (int i = 0; i < 22; i++) begin
            v = (i % 4 == 0) || (i % 4 == 3);
            step(v, (i == 0) ? IMPULSE : (v ? 24'h0 : 24'hA5A5A5));
            if (i >= 6) begin
                vexp = ((i - 6) % 4 == 0) || ((i - 6) % 4 == 3);
                if (vexp) begin
                    w0 = 16'(exp_l0[k]);
                    w1 = 16'(exp_l1[k]);
                    k++;
                end
                g0 = bus_a.dat_o[15:0];
                g1 = bus_a.dat_o[31:16];
                checks++; if (bus_a.valid_o !== vexp) begin errors++; $display("[TB] FAIL gapped valid_o step %0d: got %b want %b", i, bus_a.valid_o, vexp); end
                checks++; if (g0 !== w0) begin errors++; $display("[TB] FAIL gapped lane0 step %0d: got %0d want %0d", i, g0, w0); end
                checks++; if (g1 !== w1) begin errors++; $display("[TB] FAIL gapped lane1 step %0d: got %0d want %0d", i, g1, w1); end
            end
        end
    endtask

    task automatic test_dc();
        logic signed [15:0] g0, g1;
        for (int i = 0; i < 14; i++) begin
            step(1'b1, DC_WORD);
            if (i >= 12) begin
                g0 = bus_a.dat_o[15:0];
                g1 = bus_a.dat_o[31:16];
                checks++; if (g0 !== -16'sd10235) begin errors++; $display("[TB] FAIL dc lane0: got %0d want -10235", g0); end
                checks++; if (g1 !== -16'sd10235) begin errors++; $display("[TB] FAIL dc lane1: got %0d want -10235", g1); end
                checks++; if (bus_a.ovf_o !== 1'b0) begin errors++; $display("[TB] FAIL dc ovf_o: got %b want 0", bus_a.ovf_o); end
            end
        end
    endtask

    task automatic test_overflow();
        logic signed [11:0] g0, g1;
        for (int i = 0; i < 14; i++) begin
            bus_b.valid_i = 1'b1;
            bus_b.dat_i   = {12'h800, 12'h800};
            @(posedge clk);
            #1;
            if (i == 11) begin
                checks++; if (bus_b.ovf_o !== 1'b0) begin errors++; $display("[TB] FAIL ovf early ovf_o: got %b want 0", bus_b.ovf_o); end
                checks++; if (bus_b.valid_o !== 1'b0) begin errors++; $display("[TB] FAIL ovf early valid_o: got %b want 0", bus_b.valid_o); end
            end
            if (i >= 12) begin
                g0 = bus_b.dat_o[11:0];
                g1 = bus_b.dat_o[23:12];
                checks++; if (bus_b.valid_o !== 1'b1) begin errors++; $display("[TB] FAIL ovf valid_o: got %b want 1", bus_b.valid_o); end
                checks++; if (g0 !== 12'(OVF_EXP)) begin errors++; $display("[TB] FAIL ovf lane0: got %0d want %0d", g0, OVF_EXP); end
                checks++; if (g1 !== 12'(OVF_EXP)) begin errors++; $display("[TB] FAIL ovf lane1: got %0d want %0d", g1, OVF_EXP); end
                checks++; if (bus_b.ovf_o !== 1'b1) begin errors++; $display("[TB] FAIL ovf ovf_o: got %b want 1", bus_b.ovf_o); end
            end
        end
        bus_b.valid_i = 1'b0;
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) step(1'b1, DC_WORD);
        checks++; if (bus_a.valid_o !== 1'b1) begin errors++; $display("[TB] FAIL midreset pre valid_o: got %b want 1", bus_a.valid_o); end
        rst = 1'b1;
        #2;
        checks++; if (bus_a.valid_o !== 1'b0) begin errors++; $display("[TB] FAIL midreset valid_o: got %b want 0", bus_a.valid_o); end
        checks++; if (bus_a.primed_o !== 1'b0) begin errors++; $display("[TB] FAIL midreset primed_o: got %b want 0", bus_a.primed_o); end
        checks++; if (bus_a.dat_o !== 32'h0) begin errors++; $display("[TB] FAIL midreset dat_o: got %h want 0", bus_a.dat_o); end
        checks++; if (bus_b.ovf_o !== 1'b0) begin errors++; $display("[TB] FAIL midreset ovf_o: got %b want 0", bus_b.ovf_o); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        warmup_run("rewarm");
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_warmup();
        test_impulse();
        test_gapped();
        test_dc();
        test_overflow();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
